data_mem: RTL and testbench
===========================

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning word width in bits; it must be a multiple of 8 and at least 8.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning number of words; it must be a power of 2 and at least 2.
REQ-003 The block SHALL have derived localparam ADDR_W = $clog2(DEPTH) and STRB_W = DATA_W/8.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: request present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: request accepted when req_valid && req_ready.
REQ-008 The block SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr, input, ADDR_W bits: word address.
REQ-010 The block SHALL have port req_wdata, input, DATA_W bits: write data.
REQ-011 The block SHALL have port req_wstrb, input, STRB_W bits: per-byte write enable; bit i covers bits [8i+7:8i].
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: response present.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: response consumed when rsp_valid && rsp_ready.
REQ-014 The block SHALL have port rsp_rdata, output, DATA_W bits: word at the addressed location after any write.
REQ-015 The block SHALL have port rsp_err, output, 1 bit: parity error on the returned word.
REQ-016 The block SHALL have port init_done, output, 1 bit: high once the initialisation sweep is complete.
REQ-017 The block SHALL have port err_inject, input, 1 bit, present only with DMEM_PARITY_EN: when high on an accepted write, the stored parity is inverted.

Function
REQ-018 The FSM SHALL have three states: INIT, IDLE and RESP.
REQ-019 In INIT, the block SHALL write word k = k (zero-extended) at one address per cycle, k = 0..DEPTH-1, and then move to IDLE with init_done = 1.
REQ-020 The block SHALL hold req_ready = 1 only in IDLE, or in RESP when rsp_ready = 1 in the same cycle; req_ready SHALL be 0 throughout INIT.
REQ-021 On acceptance in cycle N, the block SHALL assert rsp_valid from cycle N+1, giving a fixed latency of 1.
REQ-022 rsp_valid and rsp_rdata SHALL stay stable until the response is consumed.
REQ-023 On a read, rsp_rdata SHALL equal mem[req_addr].
REQ-024 On a write, only the bytes selected by req_wstrb SHALL update; rsp_rdata SHALL return the merged word after the write.
REQ-025 A write with req_wstrb = 0 SHALL leave the memory unchanged and SHALL still produce a response carrying the old word.
REQ-026 A response consumed in the same cycle a new request is accepted SHALL give back-to-back responses with no bubble.
REQ-027 A read accepted in the cycle after a write to the same address SHALL return the updated data.
REQ-028 From RESP, the FSM SHALL go to IDLE on rsp_ready with no new request, and SHALL stay in RESP otherwise.
REQ-029 Address arithmetic SHALL have no out-of-range case, because DEPTH is a power of 2.

Reset
REQ-030 rst_n low SHALL asynchronously force state = INIT, sweep counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, init_done = 0 and req_ready = 0.
REQ-031 A reset asserted mid-transaction or mid-sweep SHALL drop any pending response and restart the sweep from address 0 after release.

Configuration
REQ-032 With macro DMEM_PARITY_EN defined, each word SHALL store one even-parity bit that is written on INIT and on every write.
REQ-033 With DMEM_PARITY_EN defined, rsp_err SHALL be 1 when the recomputed parity of the returned word mismatches the stored bit.
REQ-034 With DMEM_PARITY_EN defined, parity SHALL be recomputed over the merged word on a partial write.
REQ-035 Without DMEM_PARITY_EN, the block SHALL have no parity storage and no err_inject port, and rsp_err SHALL be tied to 0.

Structure
REQ-036 Package dmem_pkg SHALL hold the state enum (INIT, IDLE, RESP) and the byte-lane merge function.
REQ-037 Sub-module dmem_array SHALL hold the storage, the byte-lane write and the optional parity bits; data_mem SHALL hold the FSM, handshake and response register.

Verification
REQ-038 After reset release, the bench SHALL see init_done rise in cycle 32 for default parameters, then a read of address 5 SHALL give rsp_rdata = 5 one cycle after acceptance.
REQ-039 A write of 0xAABBCCDD with wstrb = 4'b0101 to address 3 SHALL give rsp_rdata = 0x00BB00DD, and a following read of address 3 SHALL also give 0x00BB00DD.
REQ-040 With rsp_ready held at 0 for 4 cycles, rsp_valid and rsp_rdata SHALL stay stable and req_ready SHALL stay 0; after rsp_ready = 1, a back-to-back read stream SHALL give one response per cycle.
REQ-041 With rst_n pulsed low while in RESP, rsp_valid SHALL fall immediately, and mem[7] SHALL read 7 again after init_done, even though 7 had been overwritten.
REQ-042 With DMEM_PARITY_EN, a write with err_inject = 1 to address 9 followed by a read of address 9 SHALL give rsp_err = 1, while a read of address 10 SHALL give rsp_err = 0.
REQ-043 With DATA_W = 64 and DEPTH = 16, the bench SHALL see the sweep take 16 cycles and an 8-lane strobe merge behave correctly.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data memory slice: FSM state encoding and the byte-lane merge helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RESP = 2'd2
  } state_t;

  // Widest word the merge helper supports; callers zero-extend into it and truncate back.
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  function automatic logic [MAX_DATA_W-1:0] merge_bytes(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-lane writes and a combinational read port.
// Optional even-parity bit per word when DMEM_PARITY_EN is defined.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
`ifdef DMEM_PARITY_EN
  input  logic              inj,
  output logic              perr,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] mdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];
  assign mdata = DATA_W'(merge_bytes(MAX_DATA_W'(rdata), MAX_DATA_W'(wdata), MAX_STRB_W'(wstrb)));

  // Contents are established by the init sweep, so no reset on the storage.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= mdata;
  end

`ifdef DMEM_PARITY_EN
  logic [DEPTH-1:0] par;

  always_ff @(posedge clk) begin
    if (we) par[addr] <= (^mdata) ^ inj;
  end

  // A write reports the parity it is about to store, so only an injected flip shows up.
  assign perr = we ? inj : ((^rdata) != par[addr]);
`endif

endmodule

// File: rtl/data_mem.sv
// Single-port data memory with valid/ready request and response channels and a power-up init sweep.
// Define DMEM_PARITY_EN to add per-word parity, the err_inject port and a live rsp_err.
module data_mem
  import dmem_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
`ifdef DMEM_PARITY_EN
  input  logic              err_inject,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              accept;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [STRB_W-1:0] arr_wstrb;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] mdata;
  logic [DATA_W-1:0] rsp_next;

  // A new request can enter whenever the response slot is empty or being drained this cycle.
  assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;
  assign rsp_next  = req_we ? mdata : rdata;

  always_comb begin
    arr_we    = 1'b0;
    arr_addr  = req_addr;
    arr_wdata = req_wdata;
    arr_wstrb = req_wstrb;
    if (state == INIT) begin
      arr_we    = 1'b1;
      arr_addr  = cnt;
      arr_wdata = DATA_W'(cnt);
      arr_wstrb = '1;
    end else begin
      arr_we = accept && req_we;
    end
  end

`ifdef DMEM_PARITY_EN
  logic arr_inj;
  logic perr;
  logic err_q;

  assign arr_inj = (state != INIT) && err_inject;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  dmem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .wstrb(arr_wstrb),
`ifdef DMEM_PARITY_EN
    .inj  (arr_inj),
    .perr (perr),
`endif
    .rdata(rdata),
    .mdata(mdata)
  );

  // Sweep, then alternate between waiting for a request and holding its response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      init_done <= 1'b0;
`ifdef DMEM_PARITY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rsp_next;
`ifdef DMEM_PARITY_EN
            err_q     <= perr;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            if (accept) begin
              rsp_rdata <= rsp_next;
`ifdef DMEM_PARITY_EN
              err_q     <= perr;
`endif
            end else begin
              state     <= IDLE;
              rsp_valid <= 1'b0;
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: a 32x32 instance and a 64-bit/16-word instance share clock and reset.
// Parity checks are compiled in when DMEM_PARITY_EN is defined.
module tb_data_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        req_valid, req_ready, req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err, init_done;
  logic [31:0] rsp_rdata;
`ifdef DMEM_PARITY_EN
  logic        err_inject;
`endif

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [3:0]  b_req_addr;
  logic [63:0] b_req_wdata;
  logic [7:0]  b_req_wstrb;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err, b_init_done;
  logic [63:0] b_rsp_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [63:0] d;
    logic        e;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  data_mem #(.DATA_W(32), .DEPTH(32)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
`ifdef DMEM_PARITY_EN
    .err_inject(err_inject),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done)
  );

  data_mem #(.DATA_W(64), .DEPTH(16)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_we    (b_req_we),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
    .req_wstrb (b_req_wstrb),
`ifdef DMEM_PARITY_EN
    .err_inject(1'b0),
`endif
    .rsp_valid (b_rsp_valid),
    .rsp_ready (b_rsp_ready),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err),
    .init_done (b_init_done)
  );

  function automatic void checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitors: a pending expectation must be visible as rsp_valid, and each consumed response is popped.
  always @(negedge clk) begin
    exp_t e0;
    if (rsp_valid || q0.size() != 0)
      checkOutput("d0 valid_vs_pending", 64'(rsp_valid), 64'(q0.size() != 0));
    if (rsp_valid && rsp_ready && q0.size() != 0) begin
      e0 = q0.pop_front();
      checkOutput("d0 rdata", 64'(rsp_rdata), e0.d);
      checkOutput("d0 err", 64'(rsp_err), 64'(e0.e));
    end
  end

  always @(negedge clk) begin
    exp_t e1;
    if (b_rsp_valid || q1.size() != 0)
      checkOutput("d1 valid_vs_pending", 64'(b_rsp_valid), 64'(q1.size() != 0));
    if (b_rsp_valid && b_rsp_ready && q1.size() != 0) begin
      e1 = q1.pop_front();
      checkOutput("d1 rdata", b_rsp_rdata, e1.d);
      checkOutput("d1 err", 64'(b_rsp_err), 64'(e1.e));
    end
  end

  // Called at posedge+1; returns at posedge+1 after acceptance with the expectation queued.
  task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                               input logic [3:0] ws, input logic inj, input logic [31:0] exp_d,
                               input logic exp_e, output int waits);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = ws;
`ifdef DMEM_PARITY_EN
    err_inject = inj;
`else
    if (inj) $display("[TB] note: err_inject ignored without parity");
`endif
    waits = 0;
    @(negedge clk);
    while (!req_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!req_ready) begin
      checkOutput("d0 accept_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    q0.push_back('{d: 64'(exp_d), e: exp_e});
    req_valid = 1'b0;
`ifdef DMEM_PARITY_EN
    err_inject = 1'b0;
`endif
  endtask

  task automatic applyStimulusWide(input logic we, input logic [3:0] addr, input logic [63:0] wd,
                                   input logic [7:0] ws, input logic [63:0] exp_d);
    int waits;
    b_req_valid = 1'b1;
    b_req_we    = we;
    b_req_addr  = addr;
    b_req_wdata = wd;
    b_req_wstrb = ws;
    waits = 0;
    @(negedge clk);
    while (!b_req_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!b_req_ready) begin
      checkOutput("d1 accept_timeout", 64'(b_req_ready), 64'd1);
      b_req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    q1.push_back('{d: exp_d, e: 1'b0});
    b_req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int w, c0, c1;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_wstrb = '0; b_rsp_ready = 1'b1;
`ifdef DMEM_PARITY_EN
    err_inject = 1'b0;
`endif
    #23;
    checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset req_ready", 64'(req_ready), 64'd0);
    checkOutput("reset init_done", 64'(init_done), 64'd0);
    checkOutput("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
    checkOutput("reset rsp_err", 64'(rsp_err), 64'd0);
    checkOutput("reset d1 init_done", 64'(b_init_done), 64'd0);
    checkOutput("reset d1 req_ready", 64'(b_req_ready), 64'd0);

    // Interrupt the first sweep partway, then time the restarted one.
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1 checkOutput("midsweep init_done", 64'(init_done), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    c0 = 0; c1 = 0;
    for (int cyc = 1; cyc <= 100 && (c0 == 0 || c1 == 0); cyc++) begin
      @(posedge clk); #1;
      if (cyc == 5) begin
        checkOutput("init d0 req_ready", 64'(req_ready), 64'd0);
        checkOutput("init d1 req_ready", 64'(b_req_ready), 64'd0);
        checkOutput("init d0 init_done", 64'(init_done), 64'd0);
      end
      if (init_done && c0 == 0) c0 = cyc;
      if (b_init_done && c1 == 0) c1 = cyc;
    end
    checkOutput("d0 init cycles", 64'(c0), 64'd32);
    checkOutput("d1 init cycles", 64'(c1), 64'd16);

    applyStimulus(1'b0, 5'd5, 32'h0, 4'h0, 1'b0, 32'd5, 1'b0, w);
    applyStimulus(1'b1, 5'd3, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h00BB00DD, 1'b0, w);
    applyStimulus(1'b0, 5'd3, 32'h0, 4'h0, 1'b0, 32'h00BB00DD, 1'b0, w);
    applyStimulus(1'b1, 5'd6, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'd6, 1'b0, w);
    applyStimulus(1'b0, 5'd6, 32'h0, 4'h0, 1'b0, 32'd6, 1'b0, w);
    applyStimulus(1'b0, 5'd31, 32'h0, 4'h0, 1'b0, 32'd31, 1'b0, w);
    @(posedge clk); #1;

    // Backpressure: response to address 12 must hold while the next request waits.
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 5'd12, 32'h0, 4'h0, 1'b0, 32'd12, 1'b0, w);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd13;
    repeat (4) begin
      @(negedge clk);
      checkOutput("stall rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("stall rsp_rdata", 64'(rsp_rdata), 64'd12);
      checkOutput("stall req_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    for (int a = 13; a <= 17; a++) begin
      applyStimulus(1'b0, 5'(a), 32'h0, 4'h0, 1'b0, 32'(a), 1'b0, w);
      checkOutput("stream waits", 64'(w), 64'd0);
    end
    @(posedge clk); #1;

    applyStimulusWide(1'b1, 4'd4, 64'h1122334455667788, 8'b10100101, 64'h1100330000660088);
    applyStimulusWide(1'b0, 4'd4, 64'h0, 8'h00, 64'h1100330000660088);
    applyStimulusWide(1'b0, 4'd15, 64'h0, 8'h00, 64'd15);
    applyStimulusWide(1'b1, 4'd2, 64'hFFFFFFFFFFFFFFFF, 8'b00000010, 64'h000000000000FF02);
    applyStimulusWide(1'b0, 4'd2, 64'h0, 8'h00, 64'h000000000000FF02);
    @(posedge clk); #1;

    // Overwrite address 7, then reset with a response pending and confirm the sweep restores it.
    applyStimulus(1'b1, 5'd7, 32'h12345678, 4'hF, 1'b0, 32'h12345678, 1'b0, w);
    applyStimulus(1'b0, 5'd7, 32'h0, 4'h0, 1'b0, 32'h12345678, 1'b0, w);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 5'd7, 32'h0, 4'h0, 1'b0, 32'h12345678, 1'b0, w);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_in_resp rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_in_resp rsp_rdata", 64'(rsp_rdata), 64'd0);
    checkOutput("rst_in_resp req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_in_resp init_done", 64'(init_done), 64'd0);
    q0.delete();
    @(negedge clk); rst_n = 1'b1; rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && !(init_done && b_init_done); cyc++) begin
      @(posedge clk); #1;
    end
    checkOutput("reinit d0 init_done", 64'(init_done), 64'd1);
    checkOutput("reinit d1 init_done", 64'(b_init_done), 64'd1);
    applyStimulus(1'b0, 5'd7, 32'h0, 4'h0, 1'b0, 32'd7, 1'b0, w);
    applyStimulusWide(1'b0, 4'd4, 64'h0, 8'h00, 64'd4);

`ifdef DMEM_PARITY_EN
    applyStimulus(1'b1, 5'd9, 32'h0F0F0F0F, 4'hF, 1'b1, 32'h0F0F0F0F, 1'b1, w);
    applyStimulus(1'b0, 5'd9, 32'h0, 4'h0, 1'b0, 32'h0F0F0F0F, 1'b1, w);
    applyStimulus(1'b0, 5'd10, 32'h0, 4'h0, 1'b0, 32'd10, 1'b0, w);
    applyStimulus(1'b1, 5'd9, 32'h000000FF, 4'b0001, 1'b0, 32'h0F0F0FFF, 1'b0, w);
    applyStimulus(1'b0, 5'd9, 32'h0, 4'h0, 1'b0, 32'h0F0F0FFF, 1'b0, w);
`endif

    repeat (3) @(posedge clk);
    #1;
    checkOutput("d0 drain", 64'(q0.size()), 64'd0);
    checkOutput("d1 drain", 64'(q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
